// File: rtl/if_id_queue_pkg.sv
// Shared configuration for the IF/ID instruction queue.
// Optional same-cycle bypass is enabled with the IF_ID_BYPASS_EN macro.
package if_id_queue_pkg;

    localparam int unsigned AddrLen   = 32;
    localparam int unsigned InstLen   = 32;
    localparam int unsigned IfIdDepth = 4;
    localparam logic [31:0] ZeroWord  = 32'h0000_0000;

endpackage

// File: rtl/if_id_queue_fifo_ptr_ctrl.sv
// Pointer and occupancy control for a power-of-two circular FIFO.
// Owns rd_ptr, wr_ptr and count; usable by any queue built around a plain storage array.
module if_id_queue_fifo_ptr_ctrl
    import if_id_queue_pkg::*;
#(
    parameter  int unsigned DEPTH = IfIdDepth,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push_req,
    input  logic             pop_req,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [CNT_W-1:0] count,
    output logic             full_c,
    output logic             empty_c,
    output logic             push_c
);

    logic pop_c;

    // Accept/consume decisions come only from registered occupancy.
    always_comb begin
        full_c  = (count == CNT_W'(DEPTH));
        empty_c = (count == '0);
        push_c  = push_req && !full_c;
        pop_c   = pop_req && !empty_c;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_c, pop_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/if_id_queue.sv
// DEPTH-entry {pc, inst} queue between fetch and decode with whole-queue flush.
// Define IF_ID_BYPASS_EN to forward IF straight to ID when the queue is empty.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int unsigned ADDR_W = AddrLen,
    parameter int unsigned INST_W = InstLen,
    parameter int unsigned DEPTH  = IfIdDepth,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [INST_W-1:0] if_inst,
    output logic              if_ready,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              full_c;
    logic              empty_c;
    logic              push_c;
    logic              bypass_c;
    logic              push_req_c;

`ifdef IF_ID_BYPASS_EN
    assign bypass_c = empty_c && if_valid && !flush && !rst;
`else
    assign bypass_c = 1'b0;
`endif

    // A bypassed entry that ID takes this cycle is never stored.
    assign push_req_c = if_valid && !(bypass_c && id_ready);

    if_id_queue_fifo_ptr_ctrl #(
        .DEPTH (DEPTH)
    ) u_fifo_ptr_ctrl (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .push_req (push_req_c),
        .pop_req  (id_ready),
        .rd_ptr   (rd_ptr),
        .wr_ptr   (wr_ptr),
        .count    (count),
        .full_c   (full_c),
        .empty_c  (empty_c),
        .push_c   (push_c)
    );

    always_ff @(posedge clk) begin
        if (push_c) begin
            pc_mem[wr_ptr]   <= if_pc;
            inst_mem[wr_ptr] <= if_inst;
        end
    end

    always_comb begin
        if_ready = !full_c;
        id_valid = !empty_c;
        id_pc    = ADDR_W'(ZeroWord);
        id_inst  = INST_W'(ZeroWord);
        if (bypass_c) begin
            id_valid = 1'b1;
            id_pc    = if_pc;
            id_inst  = if_inst;
        end else if (!empty_c) begin
            id_pc    = pc_mem[rd_ptr];
            id_inst  = inst_mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue (DEPTH = 4).
module tb_if_id_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_ready;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    if_id_queue #(
        .ADDR_W (32),
        .INST_W (32),
        .DEPTH  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .if_valid (if_valid),
        .if_pc    (if_pc),
        .if_inst  (if_inst),
        .if_ready (if_ready),
        .id_ready (id_ready),
        .id_valid (id_valid),
        .id_pc    (id_pc),
        .id_inst  (id_inst),
        .count    (count)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return ~pc;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; checks happen before the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_if(input logic v, input logic [31:0] pc);
        if_valid = v;
        if_pc    = pc;
        if_inst  = inst_of(pc);
    endtask

    task automatic push_stalled(input logic [31:0] pc);
        id_ready = 1'b0;
        set_if(1'b1, pc);
        tick();
        set_if(1'b0, 32'h0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; id_ready = 1'b0;
        set_if(1'b1, 32'h100);
        tick();
        tick();
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_id_pc",    id_pc,         32'h0);
        check("rst_id_inst",  id_inst,       32'h0);
        check("rst_count",    32'(count),    32'd0);
        check("rst_if_ready", 32'(if_ready), 32'd1);
        rst = 1'b0;
        set_if(1'b0, 32'h0);
        tick();
        check("post_rst_count", 32'(count), 32'd0);

        // Fill under stall, refuse fifth push, then drain in order
        for (int i = 0; i < 4; i++) push_stalled(32'(4 * i));
        check("fill_count",    32'(count),    32'd4);
        check("fill_if_ready", 32'(if_ready), 32'd0);
        check("fill_head_pc",  id_pc,         32'h0);
        push_stalled(32'h10);
        check("refused_count", 32'(count), 32'd4);
        id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_pc",   id_pc,   32'(4 * i));
            check("drain_inst", id_inst, inst_of(32'(4 * i)));
            tick();
        end
        check("drained_count", 32'(count),    32'd0);
        check("drained_valid", 32'(id_valid), 32'd0);
        check("drained_pc",    id_pc,         32'h0);

        // Simultaneous push/pop at count 2 across pointer wrap
        push_stalled(32'h100);
        push_stalled(32'h104);
        for (int k = 0; k < 10; k++) begin
            set_if(1'b1, 32'(32'h200 + 4 * k));
            id_ready = 1'b1;
            check("pp_count", 32'(count), 32'd2);
            if (k == 0)      check("pp_head", id_pc, 32'h100);
            else if (k == 1) check("pp_head", id_pc, 32'h104);
            else             check("pp_head", id_pc, 32'(32'h200 + 4 * (k - 2)));
            tick();
        end
        set_if(1'b0, 32'h0);
        check("pp_tail0", id_pc, 32'h220);
        tick();
        check("pp_tail1", id_pc, 32'h224);
        check("pp_tail1_inst", id_inst, inst_of(32'h224));
        tick();
        check("pp_empty", 32'(count), 32'd0);

        // Flush with count 3 and a concurrent push
        push_stalled(32'h300);
        push_stalled(32'h304);
        push_stalled(32'h308);
        check("pre_flush_count", 32'(count), 32'd3);
        flush = 1'b1;
        set_if(1'b1, 32'h20);
        tick();
        flush = 1'b0;
        set_if(1'b0, 32'h0);
        check("flush_count", 32'(count),    32'd0);
        check("flush_valid", 32'(id_valid), 32'd0);
        check("flush_inst",  id_inst,       32'h0);
        check("flush_pc",    id_pc,         32'h0);
        id_ready = 1'b1;
        tick();
        check("flush_no_0x20", 32'(id_valid), 32'd0);

        // Full plus pop: push refused, count drops to 3
        for (int i = 0; i < 4; i++) push_stalled(32'(32'h400 + 4 * i));
        check("full_count", 32'(count), 32'd4);
        id_ready = 1'b1;
        set_if(1'b1, 32'h500);
        check("full_head", id_pc, 32'h400);
        tick();
        set_if(1'b0, 32'h0);
        check("full_pop_count", 32'(count), 32'd3);
        for (int i = 1; i < 4; i++) begin
            check("full_drain_pc", id_pc, 32'(32'h400 + 4 * i));
            tick();
        end
        check("full_no_0x500", 32'(count), 32'd0);

        // Reset mid-operation overrides a concurrent push
        push_stalled(32'h600);
        push_stalled(32'h604);
        rst = 1'b1;
        set_if(1'b1, 32'h608);
        tick();
        rst = 1'b0;
        set_if(1'b0, 32'h0);
        check("midrst_count", 32'(count),    32'd0);
        check("midrst_valid", 32'(id_valid), 32'd0);

        // Empty queue, IF presents 0x40 with ID ready
        id_ready = 1'b1;
        if_valid = 1'b1;
        if_pc    = 32'h40;
        if_inst  = 32'h1234;
`ifdef IF_ID_BYPASS_EN
        check("byp_valid", 32'(id_valid), 32'd1);
        check("byp_pc",    id_pc,         32'h40);
        check("byp_inst",  id_inst,       32'h1234);
        tick();
        set_if(1'b0, 32'h0);
        check("byp_count", 32'(count),    32'd0);
        check("byp_after", 32'(id_valid), 32'd0);
`else
        check("nobyp_valid", 32'(id_valid), 32'd0);
        check("nobyp_pc",    id_pc,         32'h0);
        tick();
        set_if(1'b0, 32'h0);
        check("nobyp_next_pc",   id_pc,      32'h40);
        check("nobyp_next_inst", id_inst,    32'h1234);
        check("nobyp_count",     32'(count), 32'd1);
        tick();
        check("nobyp_popped", 32'(count), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register: a DEPTH-entry FIFO of {pc, inst} pairs between fetch (IF) and decode (ID).
- Decouples fetch from decode stalls: IF keeps fetching while ID is stalled, up to DEPTH entries.
- Supports a whole-queue flush on branch/jump redirect.
- An empty queue presents a zero bubble (pc = 0, inst = 0) to ID.

Parameters:
- ADDR_W, 32, pc width (matches AddrLen).
- INST_W, 32, instruction width (matches InstLen).
- DEPTH, 4, number of entries; power of two, >= 2.
- CNT_W, $clog2(DEPTH+1), occupancy counter width; derived, do not override.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  discard all entries (redirect).
- if_valid  in  1  IF presents a fetched instruction this cycle.
- if_pc  in  ADDR_W  pc of the fetched instruction.
- if_inst  in  INST_W  fetched instruction.
- if_ready  out  1  queue can accept an entry (count < DEPTH).
- id_ready  in  1  ID consumes the head this cycle (ID not stalled).
- id_valid  out  1  head entry is valid.
- id_pc  out  ADDR_W  head pc; 0 when id_valid = 0.
- id_inst  out  INST_W  head instruction; 0 when id_valid = 0.
- count  out  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset: on a rising edge with rst = 1:
  - rd_ptr, wr_ptr and count go to 0; storage contents are don't-care.
  - Resulting outputs: id_valid = 0, id_pc = 0, id_inst = 0, count = 0, if_ready = 1.
  - Reset overrides flush, push and pop, including mid-operation.
- Push: when if_valid && if_ready, the entry is written at wr_ptr and wr_ptr increments, wrapping modulo DEPTH.
- Pop: when id_ready && id_valid, rd_ptr increments, wrapping modulo DEPTH.
- Occupancy: count = count + push - pop.
  - A simultaneous push and pop leaves count unchanged.
- Latency: a pushed entry becomes visible on id_* at the earliest in the cycle after the push.
  - Exception: bypass, see Optional Feature.
- Outputs:
  - id_valid = (count != 0).
  - id_pc and id_inst are driven from storage[rd_ptr] when id_valid = 1, otherwise forced to 0.
- if_ready = (count != DEPTH); it depends only on registered state (no combinational path from id_ready).
  - When full, a push is refused even if a pop occurs in the same cycle.
- Flush:
  - On a rising edge with flush = 1 (and rst = 0), pointers and count go to 0.
  - Any push or pop in that cycle is discarded.
  - Next cycle: id_valid = 0, id_pc = 0, id_inst = 0.
- id_ready with an empty queue: ignored; no pointer movement.
- if_valid with if_ready = 0: ignored; IF holds its pc/inst until accepted.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally; full/empty is decided by count, not by pointer compare.
- No combinational loops: if_ready and id_valid never depend on if_valid or id_ready.
  - Exception: id_* under IF_ID_BYPASS_EN.

Optional Feature:
- Macro: IF_ID_BYPASS_EN.
- Defined:
  - When count == 0 and if_valid = 1 and flush = 0, the IF entry is forwarded combinationally: id_valid = 1, id_pc = if_pc, id_inst = if_inst.
  - If id_ready = 1 that cycle, the entry is consumed without being stored; pointers and count are unchanged.
  - If id_ready = 0, the entry is stored normally and appears from storage next cycle.
  - Zero-cycle latency when empty.
- Undefined: no bypass; minimum IF-to-ID latency is 1 cycle, as described in Behaviour.

Decomposition:
- Shared config header holds AddrLen, InstLen, ZeroWord, and the default queue depth define IfIdDepth.
- One natural sub-module: fifo_ptr_ctrl.
  - Parametrised on DEPTH.
  - Owns rd_ptr, wr_ptr and count, plus push/pop/flush/rst handling.
  - Reusable for a later decode or issue queue.
- Storage array and output muxing stay in if_id_queue.

Test Plan:
- Reset: assert rst for 2 cycles with if_valid = 1 and if_pc = 0x100 -> id_valid = 0, id_pc = 0, id_inst = 0, count = 0, if_ready = 1.
- Fill under stall: id_ready = 0; push pc 0x0, 0x4, 0x8, 0xC -> count = 4, if_ready = 0; a 5th push with pc 0x10 is refused; then id_ready = 1 drains 0x0, 0x4, 0x8, 0xC in order.
- Simultaneous push/pop at count = 2 -> count stays 2; order preserved across pointer wrap, verified over 10 consecutive entries.
- Flush with count = 3 and a concurrent push of 0x20 -> next cycle count = 0, id_valid = 0, id_inst = 0; 0x20 is never delivered.
- Full plus pop: count = 4, id_ready = 1, if_valid = 1 -> push refused, count = 3.
- Bypass (IF_ID_BYPASS_EN defined): empty queue, if_valid = 1, if_pc = 0x40, id_ready = 1 -> same-cycle id_pc = 0x40, count stays 0. Without the macro -> id_pc = 0x40 appears the next cycle.
